// File: rtl/dtc_share_sched_if.sv
// Request/response bundle between feature producers, the shared-classifier scheduler
// and the external classifier instance.
interface dtc_share_sched_if #(
    parameter int NREQ   = 4,
    parameter int FEAT_W = 12,
    parameter int CLS_W  = 3,
    parameter int ID_W   = $clog2(NREQ)
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*FEAT_W-1:0] req_feat;
    logic [NREQ-1:0]        req_ready;
    logic [FEAT_W-1:0]      cls_inp;
    logic [CLS_W-1:0]       cls_outp;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [CLS_W-1:0]       rsp_class;
    logic                   rsp_ready;
    logic                   busy;
    logic [15:0]            done_cnt;

    modport master (
        output req_valid, req_feat, cls_outp, rsp_ready,
        input  req_ready, cls_inp, rsp_valid, rsp_id, rsp_class, busy, done_cnt
    );

    modport slave (
        input  req_valid, req_feat, cls_outp, rsp_ready,
        output req_ready, cls_inp, rsp_valid, rsp_id, rsp_class, busy, done_cnt
    );
endinterface

// File: rtl/dtc_share_sched.sv
// Round-robin time-sharing of one combinational decision-tree classifier between
// NREQ requesters, with a programmable settle time and a valid/ready response channel.
module dtc_share_sched #(
    parameter int NREQ        = 4,
    parameter int FEAT_W      = 12,
    parameter int CLS_W       = 3,
    parameter int EVAL_CYCLES = 1,
    parameter int ID_W        = $clog2(NREQ)
) (
    input logic              clk,
    input logic              rst_n,
    dtc_share_sched_if.slave bus
);
    localparam int CNT_W = $clog2(EVAL_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [FEAT_W-1:0] feat_q;
    logic [ID_W-1:0]   id_q;
    logic [CLS_W-1:0]  class_q;
    logic              valid_q;
    logic [15:0]       done_q;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   scan_idx;
    logic [ID_W-1:0]   ptr_nxt;
    logic              accept;
    logic              rsp_hs;

    // Search starts at ptr_q and wraps, so the requester just served has lowest priority.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = ID_W'((int'(ptr_q) + k) % NREQ);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign ptr_nxt = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + ID_W'(1);
    assign accept  = (state_q == IDLE) && grant_found;
    assign rsp_hs  = (state_q == RESP) && bus.rsp_ready;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_found) state_d = EVAL;
            EVAL:    if (cnt_q == CNT_W'(1)) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant is combinational in IDLE and suppressed while reset is asserted.
    always_comb begin
        bus.req_ready = '0;
        bus.busy      = 1'b0;
        case (state_q)
            IDLE:       if (rst_n && grant_found) bus.req_ready[grant_idx] = 1'b1;
            EVAL, RESP: bus.busy = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            feat_q  <= '0;
            id_q    <= '0;
            class_q <= '0;
            valid_q <= 1'b0;
            done_q  <= '0;
        end else begin
            if (accept) begin
                feat_q <= bus.req_feat[grant_idx*FEAT_W +: FEAT_W];
                id_q   <= grant_idx;
                ptr_q  <= ptr_nxt;
                cnt_q  <= CNT_W'(EVAL_CYCLES);
            end
            if (state_q == EVAL) begin
                cnt_q <= cnt_q - CNT_W'(1);
                // Last settle cycle: the classifier output has had EVAL_CYCLES to resolve.
                if (cnt_q == CNT_W'(1)) begin
                    class_q <= bus.cls_outp;
                    valid_q <= 1'b1;
                end
            end
            if (rsp_hs) begin
                valid_q <= 1'b0;
                done_q  <= done_q + 16'd1;
            end
        end
    end

    assign bus.cls_inp   = feat_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_class = class_q;
    assign bus.done_cnt  = done_q;
endmodule

// File: tb/tb_dtc_share_sched.sv
// Directed bench for dtc_share_sched: scoreboarded responses, fairness, backpressure,
// settle time, pointer wrap, mid-EVAL reset and done counter wrap.
module tb_dtc_share_sched;
    localparam int NREQ   = 4;
    localparam int FEAT_W = 12;
    localparam int CLS_W  = 3;
    localparam int ID_W   = 2;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CLS_W-1:0] cls;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dtc_share_sched_if #(.NREQ(NREQ), .FEAT_W(FEAT_W), .CLS_W(CLS_W), .ID_W(ID_W)) bus_a ();
    dtc_share_sched_if #(.NREQ(NREQ), .FEAT_W(FEAT_W), .CLS_W(CLS_W), .ID_W(ID_W)) bus_b ();

    dtc_share_sched #(.NREQ(NREQ), .FEAT_W(FEAT_W), .CLS_W(CLS_W), .EVAL_CYCLES(1), .ID_W(ID_W))
        u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    dtc_share_sched #(.NREQ(NREQ), .FEAT_W(FEAT_W), .CLS_W(CLS_W), .EVAL_CYCLES(4), .ID_W(ID_W))
        u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    function automatic logic [CLS_W-1:0] model_cls(input logic [FEAT_W-1:0] f);
        return f[2:0] ^ f[11:9];
    endfunction

    assign bus_a.cls_outp = model_cls(bus_a.cls_inp);
    assign bus_b.cls_outp = model_cls(bus_b.cls_inp);

    rsp_t              sb_a[$];
    rsp_t              sb_b[$];
    logic [FEAT_W-1:0] feat_a [NREQ];
    int                n_vec = 0;
    int                n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_feat_a(input int i, input logic [FEAT_W-1:0] v);
        feat_a[i] = v;
        bus_a.req_feat[i*FEAT_W +: FEAT_W] = v;
    endtask

    // Compare the current response against the oldest scoreboard entry.
    task automatic expect_rsp_a(input string tag);
        rsp_t e;
        check({tag, "_valid"}, 32'(bus_a.rsp_valid), 32'd1);
        check({tag, "_sb"}, 32'(sb_a.size() > 0), 32'd1);
        if (sb_a.size() > 0) begin
            e = sb_a.pop_front();
            check({tag, "_id"}, 32'(bus_a.rsp_id), 32'(e.id));
            check({tag, "_cls"}, 32'(bus_a.rsp_class), 32'(e.cls));
        end
    endtask

    // One EVAL_CYCLES=1 transaction starting at a negedge: accept, EVAL, RESP with rsp_ready=1.
    task automatic txn_a(input string tag, input logic [NREQ-1:0] valid,
                         input int g, input logic [NREQ-1:0] after_valid);
        rsp_t e;
        bus_a.req_valid = valid;
        bus_a.rsp_ready = 1'b1;
        #1;
        check({tag, "_grant"}, 32'(bus_a.req_ready), 32'(1 << g));
        e.id  = ID_W'(g);
        e.cls = model_cls(feat_a[g]);
        sb_a.push_back(e);
        @(negedge clk);
        bus_a.req_valid = after_valid;
        #1;
        check({tag, "_eval_rdy"}, 32'(bus_a.req_ready), 32'd0);
        check({tag, "_eval_busy"}, 32'(bus_a.busy), 32'd1);
        check({tag, "_eval_vld"}, 32'(bus_a.rsp_valid), 32'd0);
        check({tag, "_cls_inp"}, 32'(bus_a.cls_inp), 32'(feat_a[g]));
        @(negedge clk);
        #1;
        expect_rsp_a(tag);
        check({tag, "_resp_rdy"}, 32'(bus_a.req_ready), 32'd0);
    endtask

    initial begin
        logic [FEAT_W-1:0] fb;
        rsp_t              eb;

        bus_a.req_valid = '0;
        bus_a.req_feat  = '0;
        bus_a.rsp_ready = 1'b1;
        bus_b.req_valid = '0;
        bus_b.req_feat  = '0;
        bus_b.rsp_ready = 1'b1;
        set_feat_a(0, 12'h123);
        set_feat_a(1, 12'h4D6);
        set_feat_a(2, 12'hA05);
        set_feat_a(3, 12'hE39);

        // Reset: grant suppressed even with every request valid.
        rst_n = 1'b0;
        bus_a.req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", 32'(bus_a.req_ready), 32'd0);
        check("rst_cls_inp", 32'(bus_a.cls_inp), 32'd0);
        check("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(bus_a.rsp_id), 32'd0);
        check("rst_rsp_class", 32'(bus_a.rsp_class), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_done", 32'(bus_a.done_cnt), 32'd0);
        check("rst_b_busy", 32'(bus_b.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.req_valid = '0;
        #1;
        check("idle_no_req", 32'(bus_a.req_ready), 32'd0);

        // Fairness: all valid, grants 0,1,2,3,0 exactly three cycles apart.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            txn_a($sformatf("rr%0d", k), 4'b1111, k % NREQ, 4'b1111);
        end
        @(negedge clk);
        bus_a.req_valid = '0;
        #1;
        check("rr_done", 32'(bus_a.done_cnt), 32'd5);

        // Single request from requester 2 (ptr is 1): class A05 -> 000.
        @(negedge clk);
        txn_a("single", 4'b0100, 2, 4'b0000);
        check("single_cls_zero", 32'(bus_a.rsp_class), 32'd0);
        @(negedge clk);
        #1;
        check("single_done", 32'(bus_a.done_cnt), 32'd6);
        check("single_keep_inp", 32'(bus_a.cls_inp), 32'hA05);
        check("single_idle", 32'(bus_a.busy), 32'd0);

        // Backpressure: six stalled RESP cycles, then handshake, next accept right after.
        @(negedge clk);
        bus_a.req_valid = 4'b1111;
        bus_a.rsp_ready = 1'b0;
        #1;
        check("bp_grant", 32'(bus_a.req_ready), 32'b1000);
        eb.id  = 2'd3;
        eb.cls = model_cls(feat_a[3]);
        sb_a.push_back(eb);
        @(negedge clk);
        #1;
        check("bp_eval_rdy", 32'(bus_a.req_ready), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp_hold%0d_vld", k), 32'(bus_a.rsp_valid), 32'd1);
            check($sformatf("bp_hold%0d_id", k), 32'(bus_a.rsp_id), 32'd3);
            check($sformatf("bp_hold%0d_cls", k), 32'(bus_a.rsp_class), 32'(eb.cls));
            check($sformatf("bp_hold%0d_rdy", k), 32'(bus_a.req_ready), 32'd0);
        end
        @(negedge clk);
        bus_a.rsp_ready = 1'b1;
        #1;
        expect_rsp_a("bp_hs");
        @(negedge clk);
        txn_a("bp_next", 4'b1111, 0, 4'b0000);
        @(negedge clk);
        bus_a.req_valid = '0;
        #1;
        check("bp_done", 32'(bus_a.done_cnt), 32'd8);

        // Pointer wrap and a requester dropping before its grant.
        @(negedge clk);
        txn_a("wrap3", 4'b1000, 3, 4'b0000);
        @(negedge clk);
        txn_a("wrap1", 4'b1010, 1, 4'b0000);
        @(negedge clk);
        txn_a("drop3a", 4'b1000, 3, 4'b1010);
        @(negedge clk);
        txn_a("drop3b", 4'b1000, 3, 4'b0000);
        @(negedge clk);
        bus_a.req_valid = '0;
        #1;
        check("drop_done", 32'(bus_a.done_cnt), 32'd12);

        // Reset in EVAL: response discarded, pending request regranted from ptr 0.
        @(negedge clk);
        bus_a.req_valid = 4'b0010;
        #1;
        check("mrst_grant", 32'(bus_a.req_ready), 32'b0010);
        @(negedge clk);
        bus_a.req_valid = 4'b0110;
        rst_n = 1'b0;
        #1;
        check("mrst_forced_rdy", 32'(bus_a.req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("mrst_cls_inp", 32'(bus_a.cls_inp), 32'd0);
        check("mrst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("mrst_rsp_id", 32'(bus_a.rsp_id), 32'd0);
        check("mrst_rsp_class", 32'(bus_a.rsp_class), 32'd0);
        check("mrst_busy", 32'(bus_a.busy), 32'd0);
        check("mrst_done", 32'(bus_a.done_cnt), 32'd0);
        rst_n = 1'b1;
        txn_a("mrst_regrant", 4'b0110, 1, 4'b0000);
        @(negedge clk);
        bus_a.req_valid = '0;
        #1;
        check("mrst_done_after", 32'(bus_a.done_cnt), 32'd1);

        // Done counter wrap from 0xFFFF.
        force u_dut_a.done_q = 16'hFFFF;
        @(negedge clk);
        release u_dut_a.done_q;
        #1;
        check("cnt_preload", 32'(bus_a.done_cnt), 32'hFFFF);
        @(negedge clk);
        txn_a("cnt_wrap", 4'b0001, 0, 4'b0000);
        @(negedge clk);
        #1;
        check("cnt_wrapped", 32'(bus_a.done_cnt), 32'd0);

        // Settle time with EVAL_CYCLES=4: accept at T, EVAL T+1..T+4, rsp_valid at T+5.
        fb = 12'h3C7;
        bus_b.req_feat[1*FEAT_W +: FEAT_W] = fb;
        @(negedge clk);
        bus_b.req_valid = 4'b0010;
        #1;
        check("set_grant", 32'(bus_b.req_ready), 32'b0010);
        eb.id  = 2'd1;
        eb.cls = model_cls(fb);
        sb_b.push_back(eb);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus_b.req_valid = '0;
            bus_b.req_feat[1*FEAT_W +: FEAT_W] = 12'h000;
            #1;
            check($sformatf("set_t%0d_inp", k), 32'(bus_b.cls_inp), 32'(fb));
            check($sformatf("set_t%0d_busy", k), 32'(bus_b.busy), 32'd1);
            check($sformatf("set_t%0d_vld", k), 32'(bus_b.rsp_valid), 32'd0);
        end
        @(negedge clk);
        #1;
        check("set_rsp_valid", 32'(bus_b.rsp_valid), 32'd1);
        check("set_sb", 32'(sb_b.size()), 32'd1);
        if (sb_b.size() > 0) begin
            eb = sb_b.pop_front();
            check("set_rsp_id", 32'(bus_b.rsp_id), 32'(eb.id));
            check("set_rsp_class", 32'(bus_b.rsp_class), 32'(eb.cls));
        end
        @(negedge clk);
        #1;
        check("set_done", 32'(bus_b.done_cnt), 32'd1);
        check("set_idle", 32'(bus_b.busy), 32'd0);
        check("sb_a_empty", 32'(sb_a.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
